pc_sequencer: RTL and testbench

Parametrised program-counter sequencer replacing the single-level PC / next-PC / exception-return path of the unpipelined core. It holds the PC and computes sequential, branch, jump and jump-register targets. It takes prioritised synchronous exceptions and vectored external interrupts, and keeps a hardware return stack so handlers may nest up to a configurable depth. It sits between the control unit / ALU flags and the instruction ROM address port.

---
 rtl/pc_seq_pkg.sv | 15 +
 rtl/ret_stack.sv | 34 +++
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared cause codes and sizing helpers for the PC sequencer
package pc_seq_pkg;
  localparam int CAUSE_INVALID = 0;
  localparam int CAUSE_OVF     = 1;
  localparam int CAUSE_IRQ0    = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int frame_w(input int addr_w);
    return addr_w + 1;
  endfunction
endpackage

// File: rtl/ret_stack.sv
// ret_stack: parametrised LIFO of handler return frames
// i_push/i_pop: single push or pop per cycle (push ignored when full, pop ignored when empty)
// i_data: frame to push; o_data: combinational top of stack
// o_depth: occupancy; o_full/o_empty: occupancy flags
module ret_stack import pc_seq_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = 31
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [W-1:0]          i_data,
  output logic [W-1:0]          o_data,
  output logic [clog2(DEPTH):0] o_depth,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] ptr;
  // DEPTH is a power of two and ptr never exceeds it, so the MSB alone marks full
  assign o_full  = ptr[AW];
  assign o_empty = ptr == '0;
  assign o_depth = ptr;
  assign o_data  = mem[AW'(ptr - ONE)];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) ptr <= '0;
    else if (i_push && !o_full) ptr <= ptr + ONE;
    else if (i_pop && !o_empty) ptr <= ptr - ONE;
  always_ff @(posedge i_clk)
    if (i_push && !o_full) mem[ptr[AW-1:0]] <= i_data;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch/jump targets, prioritised exceptions, vectored IRQs and nested return stack
// i_clk/i_rst_n: clock and async active-low reset; i_stall: freeze all state
// i_j/i_jr/i_beq/i_bne/i_zero/i_imm26/i_adr_jr: control-flow inputs
// i_invalid_instr/i_overflow: sync exceptions; i_irq: level IRQs; i_eret: handler return
// i_ie_we/i_ie_data: interrupt-enable write
// o_pc/o_pc_next: current and next PC; o_cause/o_depth/o_ie/o_stack_err: handler status
module pc_sequencer import pc_seq_pkg::*; #(
  parameter int ADDR_W       = 30,
  parameter int NUM_IRQ      = 4,
  parameter int STACK_DEPTH  = 4,
  parameter int RESET_VECTOR = 0,
  parameter int VECTOR_BASE  = 'h20,
  localparam int CAUSE_W     = clog2(NUM_IRQ + 2),
  localparam int DEPTH_W     = clog2(STACK_DEPTH) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_j,
  input  logic               i_jr,
  input  logic               i_beq,
  input  logic               i_bne,
  input  logic               i_zero,
  input  logic [25:0]        i_imm26,
  input  logic [31:0]        i_adr_jr,
  input  logic               i_invalid_instr,
  input  logic               i_overflow,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_eret,
  input  logic               i_ie_we,
  input  logic               i_ie_data,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [ADDR_W-1:0]  o_pc_next,
  output logic [CAUSE_W-1:0] o_cause,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_ie,
  output logic               o_stack_err
);
  localparam int FW = frame_w(ADDR_W);
  localparam logic [ADDR_W-1:0] JMASK = ADDR_W'({26{1'b1}});
  logic [ADDR_W-1:0] pc1, br, jmp, jr, nrm, vec, ret_pc;
  logic [FW-1:0] top;
  logic [CAUSE_W-1:0] code, irq_code;
  logic full, empty, sync_req, exc, do_eret, irq_any, irq_go, ent, push, pop;
  logic unused_adr;
  assign unused_adr = ^i_adr_jr;
  assign pc1 = o_pc + ADDR_W'(1);
  assign br  = pc1 + {{(ADDR_W-16){i_imm26[15]}}, i_imm26[15:0]};
  assign jmp = (pc1 & ~JMASK) | ADDR_W'(i_imm26);
  assign jr  = i_adr_jr[ADDR_W+1:2];
  assign nrm = i_jr ? jr : i_j ? jmp : ((i_beq & i_zero) | (i_bne & ~i_zero)) ? br : pc1;
  // Scan downward so the lowest-index pending line wins
  always_comb begin
    irq_code = '0;
    irq_any  = 1'b0;
    for (int k = NUM_IRQ - 1; k >= 0; k--)
      if (i_irq[k]) begin
        irq_any  = 1'b1;
        irq_code = CAUSE_W'(CAUSE_IRQ0 + k);
      end
  end
  assign sync_req = i_invalid_instr | i_overflow;
  assign exc      = ~i_stall & sync_req;
  assign do_eret  = ~i_stall & ~sync_req & i_eret;
  assign irq_go   = ~i_stall & ~sync_req & ~i_eret & o_ie & ~full & irq_any;
  assign ent      = exc | irq_go;
  assign code     = exc ? (i_invalid_instr ? CAUSE_W'(CAUSE_INVALID) : CAUSE_W'(CAUSE_OVF)) : irq_code;
  assign vec      = ADDR_W'(VECTOR_BASE) + ADDR_W'(code);
  // A sync exception on a full stack still vectors but drops its frame
  assign push     = (exc & ~full) | irq_go;
  assign pop      = do_eret & ~empty;
  assign ret_pc   = exc ? pc1 : nrm;
  assign o_pc_next = i_stall ? o_pc : ent ? vec : do_eret ? (empty ? pc1 : top[FW-1:1]) : nrm;
  ret_stack #(.DEPTH(STACK_DEPTH), .W(FW)) u_stack (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  ({ret_pc, o_ie}),
    .o_data  (top),
    .o_depth (o_depth),
    .o_full  (full),
    .o_empty (empty)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_pc        <= ADDR_W'(RESET_VECTOR);
      o_ie        <= 1'b0;
      o_cause     <= '0;
      o_stack_err <= 1'b0;
    end else begin
      o_pc        <= o_pc_next;
      o_ie        <= ent ? 1'b0 : pop ? top[0] : (~i_stall & ~do_eret & i_ie_we) ? i_ie_data : o_ie;
      o_cause     <= ent ? code : o_cause;
      o_stack_err <= o_stack_err | (exc & full) | (do_eret & empty);
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench with directed scenarios and random stimulus against a behavioural model
module tb_pc_sequencer;
  localparam longint M = 64'd1 << 30;
  typedef struct packed {
    logic stall, j, jr, beq, bne, zero, inv, ovf, eret, ie_we, ie_data;
    logic [25:0] imm;
    logic [31:0] adr;
    logic [3:0] irq;
  } stim_t;
  typedef struct {longint pc; int depth; bit ie; int cause; bit err;} exp_t;
  typedef struct {longint pc; bit ie;} frame_t;
  logic clk = 0, rst_n = 0;
  stim_t st = '0;
  logic [29:0] o_pc, o_pc_next;
  logic [2:0] o_cause, o_depth;
  logic o_ie, o_stack_err;
  exp_t q[$];
  frame_t stk[$];
  longint mpc;
  bit mie, merr;
  int mcause;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pc_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(st.stall), .i_j(st.j), .i_jr(st.jr),
    .i_beq(st.beq), .i_bne(st.bne), .i_zero(st.zero), .i_imm26(st.imm), .i_adr_jr(st.adr),
    .i_invalid_instr(st.inv), .i_overflow(st.ovf), .i_irq(st.irq), .i_eret(st.eret),
    .i_ie_we(st.ie_we), .i_ie_data(st.ie_data), .o_pc(o_pc), .o_pc_next(o_pc_next),
    .o_cause(o_cause), .o_depth(o_depth), .o_ie(o_ie), .o_stack_err(o_stack_err)
  );
  function automatic void check(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction
  function automatic stim_t rnd_stim();
    stim_t s;
    s.stall = ($urandom % 8) == 0;
    s.j = ($urandom % 6) == 0;
    s.jr = ($urandom % 8) == 0;
    s.beq = ($urandom % 4) == 0;
    s.bne = ($urandom % 4) == 0;
    s.zero = 1'($urandom);
    s.inv = ($urandom % 20) == 0;
    s.ovf = ($urandom % 20) == 0;
    s.eret = ($urandom % 6) == 0;
    s.ie_we = ($urandom % 4) == 0;
    s.ie_data = 1'($urandom);
    s.imm = 26'($urandom);
    s.adr = $urandom;
    s.irq = ($urandom % 3) == 0 ? 4'($urandom) : 4'd0;
    return s;
  endfunction
  // Drive one cycle of stimulus, predict the post-edge state and queue it
  task automatic cyc(input stim_t s);
    longint p1, nrm, sx, nxt;
    int k;
    frame_t f;
    @(negedge clk);
    st = s;
    #1;
    p1 = (mpc + 1) % M;
    sx = s.imm[15] ? longint'(s.imm[15:0]) - 65536 : longint'(s.imm[15:0]);
    if (s.jr) nrm = (longint'(s.adr) / 4) % M;
    else if (s.j) nrm = (p1 / (64'd1 << 26)) * (64'd1 << 26) + longint'(s.imm);
    else if ((s.beq && s.zero) || (s.bne && !s.zero)) nrm = (p1 + sx + M) % M;
    else nrm = p1;
    if (s.stall) nxt = mpc;
    else if (s.inv || s.ovf) begin
      mcause = s.inv ? 0 : 1;
      if (stk.size() < 4) stk.push_back('{p1, mie});
      else merr = 1;
      mie = 0;
      nxt = 'h20 + mcause;
    end else if (s.eret) begin
      if (stk.size() > 0) begin
        f = stk.pop_back();
        nxt = f.pc;
        mie = f.ie;
      end else begin
        nxt = p1;
        merr = 1;
      end
    end else if (mie && stk.size() < 4 && s.irq != 0) begin
      for (k = 0; k < 4; k++) if (s.irq[k]) break;
      stk.push_back('{nrm, mie});
      mie = 0;
      mcause = 2 + k;
      nxt = 'h20 + mcause;
    end else begin
      nxt = nrm;
      if (s.ie_we) mie = s.ie_data;
    end
    check("pc_next", o_pc_next, nxt);
    mpc = nxt;
    q.push_back('{mpc, stk.size(), mie, mcause, merr});
  endtask
  task automatic at_edge();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    at_edge();
    rst_n = 0;
    st = '0;
    #1;
    check("rst_pc", o_pc, 0);
    check("rst_depth", o_depth, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    check("rst_ie", o_ie, 0);
    check("rst_cause", o_cause, 0);
    check("rst_err", o_stack_err, 0);
    mpc = 0; mie = 0; mcause = 0; merr = 0;
    stk.delete();
    q.delete();
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc", o_pc, e.pc);
        check("depth", o_depth, e.depth);
        check("ie", o_ie, e.ie);
        check("cause", o_cause, e.cause);
        check("stack_err", o_stack_err, e.err);
      end
    end
  end
  initial begin : stimulus
    stim_t s;
    do_reset();
    s = '0;
    repeat (3) cyc(s);
    at_edge(); check("plain3", o_pc, 3);
    s = '0; s.j = 1; s.imm = 10; cyc(s);
    s = '0; s.beq = 1; s.zero = 1; s.imm = 26'hFFFE; cyc(s);
    at_edge(); check("beq_back", o_pc, 9);
    s = '0; s.j = 1; s.imm = 'h40; cyc(s);
    at_edge(); check("jump", o_pc, 'h40);
    s = '0; s.jr = 1; s.adr = 'h100; cyc(s);
    at_edge(); check("jr", o_pc, 'h40);
    s = '0; s.j = 1; s.imm = 5; s.ie_we = 1; s.ie_data = 1; cyc(s);
    at_edge(); check("ie_set", o_ie, 1);
    s = '0; s.irq = 4'b0110; cyc(s);
    at_edge(); check("irq_pc", o_pc, 'h23); check("irq_cause", o_cause, 3); check("irq_depth", o_depth, 1); check("irq_ie", o_ie, 0);
    s = '0; s.ovf = 1; cyc(s);
    at_edge(); check("nest_pc", o_pc, 'h21); check("nest_depth", o_depth, 2);
    s = '0; s.eret = 1; cyc(s);
    at_edge(); check("eret1_pc", o_pc, 'h24);
    cyc(s);
    at_edge(); check("eret2_pc", o_pc, 6); check("eret2_ie", o_ie, 1);
    s = '0; s.inv = 1;
    repeat (4) cyc(s);
    s.irq = 4'b0001; cyc(s);
    at_edge(); check("ovfl_depth", o_depth, 4); check("ovfl_err", o_stack_err, 1); check("ovfl_pc", o_pc, 'h20);
    s = '0; s.irq = 4'b0001; cyc(s);
    at_edge(); check("masked_irq_pc", o_pc, 'h21);
    do_reset();
    s = '0; s.j = 1; s.imm = 7; cyc(s);
    s = '0; s.eret = 1; cyc(s);
    at_edge(); check("empty_eret_pc", o_pc, 8); check("empty_eret_err", o_stack_err, 1);
    do_reset();
    s = '0; s.ie_we = 1; s.ie_data = 1; cyc(s);
    s = '0; s.stall = 1; s.irq = 4'b0001;
    repeat (3) cyc(s);
    at_edge(); check("stall_pc", o_pc, 1);
    s.stall = 0; cyc(s);
    at_edge(); check("stall_rel_pc", o_pc, 'h22); check("stall_rel_depth", o_depth, 1);
    do_reset();
    repeat (4) begin
      do_reset();
      repeat (100) cyc(rnd_stim());
    end
    at_edge();
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
